seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised, runtime-programmable serial bit-sequence detector; successor to the fixed 101010 Mealy FSM.
//  Pattern (1..MAX_LEN bits) and length load at runtime; overlap/non-overlap selectable; Mealy or registered output.
//  Adds in_valid qualifier, partial-match progress output and saturating match counter. Sits on serial bit streams.
// PARAMETERS
//  MAX_LEN          8            max pattern length in bits (>=2)
//  DEFAULT_PATTERN  8'b00101010  pattern after reset (LSB-aligned, bits [len-1:0] used)
//  DEFAULT_LEN      6            pattern length after reset (0..MAX_LEN)
//  MEALY            1            1: out combinational from current in; 0: out registered (+1 cycle)
//  CNT_W            16           match_count width
//  LEN_W (localparam) = $clog2(MAX_LEN+1)
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        synchronous, active-low reset
//  in_valid     in   1        in is sampled only when 1
//  in           in   1        serial data bit
//  cfg_load     in   1        1-cycle pulse: load cfg_pattern/cfg_len
//  cfg_pattern  in   MAX_LEN  new pattern; cfg_pattern[len-1] is the first bit received
//  cfg_len      in   LEN_W    new length; 0 = detector disabled; >MAX_LEN clamped to MAX_LEN
//  overlap_en   in   1        1: overlapping matches allowed; 0: history cleared after each match
//  out          out  1        match pulse (1 cycle)
//  state        out  LEN_W    registered partial-match length (longest pattern prefix ending at last accepted bit)
//  match_count  out  CNT_W    number of matches since reset/cfg_load, saturates at all-ones
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, history=0, fill=0, state=0,
//    match_count=0, registered out=0. MEALY=1: out forced 0 while reset==0. Reset beats cfg_load and in_valid.
//  - Internal: history h[MAX_LEN-1:0] (h[0] newest bit), fill counter 0..MAX_LEN (saturating) of bits accepted.
//  - hit = in_valid & len!=0 & (fill+1 >= len) & ({h[len-2:0],in} == pattern[len-1:0]); len==1 compares in only.
//  - MEALY=1: out = hit, same cycle as the completing bit. MEALY=0: out <= hit, asserted the following cycle for 1 cycle.
//  - On accepted bit (in_valid=1): h <= {h,in}; fill <= fill+1 (sat). On hit with overlap_en=0: fill <= 0, state <= 0.
//  - in_valid=0: h, fill, state hold; MEALY=1 out=0; MEALY=0 out <= 0.
//  - state: after each accepted bit, largest k < len with h'[k-1:0]==pattern[len-1:len-k] and k<=fill';
//    overlap_en=1 after hit -> longest proper prefix/suffix overlap (101010 -> 4).
//  - match_count increments by 1 on each hit; holds at 2^CNT_W-1.
//  - cfg_load (reset==1): pattern/len latch; h, fill, state, match_count, registered out cleared;
//    a same-cycle in bit is discarded and no hit is produced that cycle.
//  - overlap_en sampled at each hit; changes mid-stream take effect on next hit. No state is lost on change.
//  - len==0: out never asserts, state=0, counter holds; bits still shift into h.
// STRUCTURE
//  - Package seq_detect_pkg: clog2-based LEN_W function, default pattern/length constants, MAX_LEN limit check.
//  - Sub-module seq_prefix_match (combinational): inputs h, in, pattern, len, fill -> hit, next_state.
//    Top holds registers (pattern, len, h, fill, state, out_q, match_count) and cfg/reset priority.
// TESTING (clk period 10; defaults unless stated)
//  1 Reset: hold reset=0 3 cycles with in toggling -> out=0, state=0, match_count=0 throughout.
//  2 Overlap: overlap_en=1, in_valid=1, stream 1,0,1,0,1,0,1,0 -> out on bits 6 and 8 (MEALY=1, same cycle);
//    state after bit 6 = 4; match_count=2.
//  3 Non-overlap: same stream, overlap_en=0 -> out on bit 6 only; state=0 after bit 6; match_count=1;
//    continuing 1,0,1,0 (bits 9..12) -> second out on bit 12.
//  4 Gaps/MEALY=0: stream 1,0,1,0,1,0 with in_valid=0 for 2 cycles between bits 3 and 4 -> one match;
//    MEALY=0 build: out one cycle after bit 6, width 1 cycle.
//  5 Reconfig: cfg_load with cfg_pattern=3'b110, cfg_len=3 mid-stream, same-cycle in_valid=1 -> bit ignored,
//    match_count=0; then 1,1,0,1,1,0 -> 2 hits; cfg_len=0 -> no hits on any stream; cfg_len=9 clamps to 8.
//  6 Saturation/priority: CNT_W=4 build, 20 hits of pattern 1 (len=1) -> match_count sticks at 15;
//    reset=0 together with cfg_load -> defaults restored, cfg ignored.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the runtime-programmable serial sequence detector.
package seq_detect_pkg;

  localparam int         DFLT_MAX_LEN = 8;
  localparam logic [7:0] DFLT_PATTERN = 8'b0010_1010;
  localparam int         DFLT_LEN     = 6;
  localparam int         DFLT_CNT_W   = 16;

  typedef enum logic {
    OUT_REG   = 1'b0,
    OUT_MEALY = 1'b1
  } out_mode_e;

  // Width needed to hold a length 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic bit max_len_ok(input int max_len);
    return max_len >= 2;
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational pattern compare: full-length hit and longest pattern prefix
// ending at the incoming bit.
module seq_prefix_match
  import seq_detect_pkg::*;
#(
  parameter int    MAX_LEN = DFLT_MAX_LEN,
  localparam int   LEN_W   = len_w(MAX_LEN)
) (
  input  logic [MAX_LEN-2:0] h,
  input  logic               in_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [LEN_W-1:0]   fill,
  output logic               match,
  output logic [LEN_W-1:0]   next_state
);

  logic [MAX_LEN-1:0] hn;
  logic               sfx_ok;
  int                 l;
  int                 fl;

  function automatic logic [MAX_LEN-1:0] low_mask(input int n);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    hn         = {h, in_bit};
    l          = int'(len);
    fl         = int'(fill) + 1;
    match      = 1'b0;
    next_state = '0;
    sfx_ok     = 1'b0;
    if (l != 0 && fl >= l) begin
      match = ((hn ^ pattern) & low_mask(l)) == '0;
    end
    // Newest k bits against the first k pattern bits, i.e. pattern[l-1:l-k].
    for (int k = 1; k < MAX_LEN; k++) begin
      if (k < l && k <= fl) begin
        sfx_ok = ((hn ^ (pattern >> (l - k))) & low_mask(k)) == '0;
        if (sfx_ok) next_state = LEN_W'(k);
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-sequence detector with match counter.
//   state | meaning
//   0     | no pattern prefix ends at the last accepted bit
//   k     | last k accepted bits equal the first k pattern bits (k < len)
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN         = DFLT_MAX_LEN,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DFLT_PATTERN),
  parameter int                 DEFAULT_LEN     = DFLT_LEN,
  parameter bit                 MEALY           = 1'b1,
  parameter int                 CNT_W           = DFLT_CNT_W,
  localparam int                LEN_W           = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               overlap_en,
  output logic               out,
  output logic [LEN_W-1:0]   state,
  output logic [CNT_W-1:0]   match_count
);

  localparam int        HW       = MAX_LEN - 1;
  localparam out_mode_e OUT_MODE = MEALY ? OUT_MEALY : OUT_REG;

  if (!max_len_ok(MAX_LEN)) begin : g_bad_max_len
    $error("seq_detect_param: MAX_LEN must be >= 2");
  end

  // The oldest history bit is never compared, so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [HW-1:0]      h_q, h_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  logic [LEN_W-1:0]   state_q, state_d, next_state;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               match;
  logic               hit;

  seq_prefix_match #(
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .h          (h_q),
    .in_bit     (in),
    .pattern    (pattern_q),
    .len        (len_q),
    .fill       (fill_q),
    .match      (match),
    .next_state (next_state)
  );

  assign hit      = in_valid & ~cfg_load & match;
  assign fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    h_d       = h_q;
    fill_d    = fill_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      h_d       = '0;
      fill_d    = '0;
      state_d   = '0;
      cnt_d     = '0;
    end else if (in_valid) begin
      h_d     = HW'({h_q, in});
      fill_d  = fill_inc;
      state_d = next_state;
      out_d   = hit;
      if (hit) begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (!overlap_en) begin
          fill_d  = '0;
          state_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pattern_q <= DEFAULT_PATTERN;
      len_q     <= LEN_W'(DEFAULT_LEN);
      h_q       <= '0;
      fill_q    <= '0;
      state_q   <= '0;
      cnt_q     <= '0;
      out_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      h_q       <= h_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
    end
  end

  assign out         = (OUT_MODE == OUT_MEALY) ? (hit & reset) : out_q;
  assign state       = state_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: Mealy, registered-output and narrow-counter
// instances share one stimulus stream.
module tb_seq_detect_param;

  typedef struct {
    int         tag;
    bit         rst;
    bit         ld;
    bit         vld;
    bit         b;
    bit         ovl;
    logic [7:0] pat;
    logic [3:0] len;
    bit         eo;
    int         es;
    int         ec;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_bit, cfg_load, overlap_en;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        out_a, out_r, out_c;
  logic [3:0]  st_a, st_r, st_c;
  logic [15:0] cnt_a, cnt_r;
  logic [3:0]  cnt_c;

  int checks   = 0;
  int failures = 0;
  int s_out_a, s_out_c, s_out_r, s_st, s_cnt, s_cnt_c;

  always #5 clk = ~clk;

  seq_detect_param #(.MEALY(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .out(out_a), .state(st_a), .match_count(cnt_a));

  seq_detect_param #(.MEALY(1'b0)) dut_r (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .out(out_r), .state(st_r), .match_count(cnt_r));

  seq_detect_param #(.MEALY(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .out(out_c), .state(st_c), .match_count(cnt_c));

  function automatic vec_t mk(input int tag, input bit rst, input bit ld, input bit vld,
                              input bit b, input bit ovl, input logic [7:0] pat,
                              input logic [3:0] len, input bit eo, input int es, input int ec);
    vec_t v;
    v.tag = tag; v.rst = rst; v.ld = ld; v.vld = vld; v.b = b; v.ovl = ovl;
    v.pat = pat; v.len = len; v.eo = eo; v.es = es; v.ec = ec;
    return v;
  endfunction

  // Drive on the falling edge, sample Mealy outputs just before the rising
  // edge and registered values 1 time unit after it.
  task automatic step(input vec_t v);
    @(negedge clk);
    reset       = v.rst;
    cfg_load    = v.ld;
    in_valid    = v.vld;
    in_bit      = v.b;
    overlap_en  = v.ovl;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    #4;
    s_out_a = int'(out_a);
    s_out_c = int'(out_c);
    @(posedge clk);
    #1;
    s_out_r = int'(out_r);
    s_st    = int'(st_a);
    s_cnt   = int'(cnt_a);
    s_cnt_c = int'(cnt_c);
  endtask

  task automatic chk(input int tag, input int idx, input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL t%0d v%0d %s: got=%0d expected=%0d", tag, idx, nm, got, exp);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   sb[12];
    int   eo[12];
    int   es[12];
    int   ec[12];
    int   pst[6];

    reset = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    overlap_en = 1'b1; cfg_pattern = '0; cfg_len = '0;

    // 1: reset held with toggling input
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 1, (i % 2) == 0, 1, 0, 0, 0, 0, 0));

    // 2: overlapping 101010 on 10101010
    sb = '{1,0,1,0,1,0,1,0,0,0,0,0};
    eo = '{0,0,0,0,0,1,0,1,0,0,0,0};
    es = '{1,2,3,4,5,4,5,4,0,0,0,0};
    ec = '{0,0,0,0,0,1,1,2,0,0,0,0};
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(2, 1, 0, 1, sb[i] == 1, 1, 0, 0, eo[i] == 1, es[i], ec[i]));
    vecs.push_back(mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // 3: non-overlapping, twelve bits
    sb = '{1,0,1,0,1,0,1,0,1,0,1,0};
    eo = '{0,0,0,0,0,1,0,0,0,0,0,1};
    es = '{1,2,3,4,5,0,1,2,3,4,5,0};
    ec = '{0,0,0,0,0,1,1,1,1,1,1,2};
    for (int i = 0; i < 12; i++)
      vecs.push_back(mk(3, 1, 0, 1, sb[i] == 1, 0, 0, 0, eo[i] == 1, es[i], ec[i]));
    vecs.push_back(mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // 4: in_valid gaps between bits 3 and 4; trailing idle checks pulse width
    vecs.push_back(mk(4, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4, 1, 0, 1, 0, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(4, 1, 0, 1, 1, 1, 0, 0, 0, 3, 0));
    vecs.push_back(mk(4, 1, 0, 0, 1, 1, 0, 0, 0, 3, 0));
    vecs.push_back(mk(4, 1, 0, 0, 0, 1, 0, 0, 0, 3, 0));
    vecs.push_back(mk(4, 1, 0, 1, 0, 1, 0, 0, 0, 4, 0));
    vecs.push_back(mk(4, 1, 0, 1, 1, 1, 0, 0, 0, 5, 0));
    vecs.push_back(mk(4, 1, 0, 1, 0, 1, 0, 0, 1, 4, 1));
    vecs.push_back(mk(4, 1, 0, 0, 0, 1, 0, 0, 0, 4, 1));

    // 5: reconfig to 110/len3 with a same-cycle bit that must be dropped
    vecs.push_back(mk(5, 1, 1, 1, 1, 1, 8'b110, 4'd3, 0, 0, 0));
    sb = '{1,1,0,1,1,0,0,0,0,0,0,0};
    eo = '{0,0,1,0,0,1,0,0,0,0,0,0};
    es = '{1,2,0,1,2,0,0,0,0,0,0,0};
    ec = '{0,0,1,1,1,2,0,0,0,0,0,0};
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(5, 1, 0, 1, sb[i] == 1, 1, 0, 0, eo[i] == 1, es[i], ec[i]));
    vecs.push_back(mk(5, 1, 1, 0, 0, 1, 8'b110, 4'd0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(5, 1, 0, 1, sb[i] == 1, 1, 0, 0, 0, 0, 0));
    // length 9 clamps to 8: pattern 10100101 needs all eight bits
    vecs.push_back(mk(5, 1, 1, 0, 0, 1, 8'hA5, 4'd9, 0, 0, 0));
    sb = '{1,0,1,0,0,1,0,1,0,0,0,0};
    eo = '{0,0,0,0,0,0,0,1,0,0,0,0};
    es = '{1,2,3,4,5,6,7,3,0,0,0,0};
    ec = '{0,0,0,0,0,0,0,1,0,0,0,0};
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(5, 1, 0, 1, sb[i] == 1, 1, 0, 0, eo[i] == 1, es[i], ec[i]));

    foreach (vecs[i]) begin
      step(vecs[i]);
      chk(vecs[i].tag, i, "out_mealy", s_out_a, int'(vecs[i].eo));
      chk(vecs[i].tag, i, "out_reg",   s_out_r, int'(vecs[i].eo));
      chk(vecs[i].tag, i, "state",     s_st,    vecs[i].es);
      chk(vecs[i].tag, i, "count",     s_cnt,   vecs[i].ec);
    end

    // 6a: 20 hits of single-bit pattern, 4-bit counter saturates at 15
    step(mk(6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step(mk(6, 1, 1, 0, 0, 1, 8'b1, 4'd1, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      step(mk(6, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0));
      chk(6, i, "sat_out",   s_out_c, 1);
      chk(6, i, "sat_count", s_cnt_c, (i + 1 < 15) ? i + 1 : 15);
    end
    chk(6, 20, "wide_count", s_cnt, 20);
    chk(6, 20, "len1_state", s_st, 0);

    // 6b: reset wins over a simultaneous cfg_load; default 101010 comes back
    step(mk(6, 0, 1, 1, 1, 1, 8'b110, 4'd3, 0, 0, 0));
    chk(6, 21, "prio_state", s_st, 0);
    chk(6, 21, "prio_count", s_cnt, 0);
    pst = '{1,2,3,4,5,4};
    for (int i = 0; i < 6; i++) begin
      step(mk(6, 1, 0, 1, (i % 2) == 0, 1, 0, 0, 0, 0, 0));
      chk(6, 22 + i, "prio_out",   s_out_a, (i == 5) ? 1 : 0);
      chk(6, 22 + i, "prio_state", s_st, pst[i]);
    end
    chk(6, 28, "prio_count", s_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
